// File: rtl/get_altitude_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// get_altitude_pkg : state encoding and unit constants for get_altitude
// Revision 1.0
// ---------------------------------------------------------------------------
package get_altitude_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_BURN    = 3'd1,
      S_COAST   = 3'd2,
      S_DESCENT = 3'd3,
      S_LANDED  = 3'd4
   } state_e;

   localparam longint NM_PER_MM       = 64'sd1_000_000;
   localparam longint FM_PER_MM       = 64'sd1_000_000_000_000;
   localparam int     GRAVITY_DEFAULT = 9_799;

endpackage
`default_nettype wire

// File: rtl/get_altitude_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// get_altitude_if : velocity-stage inputs and telemetry outputs of get_altitude
// Revision 1.0
// ---------------------------------------------------------------------------
interface get_altitude_if;

   logic               launch;
   logic signed [63:0] velocity;
   logic               backward;
   logic               ignition_end;
   logic signed [63:0] altitude;
   logic signed [63:0] apogee;
   logic               apogee_valid;
   logic               landed;
   logic [2:0]         state;
   logic               out_valid;

   modport master (
      output launch, velocity, backward, ignition_end,
      input  altitude, apogee, apogee_valid, landed, state, out_valid
   );

   modport slave (
      input  launch, velocity, backward, ignition_end,
      output altitude, apogee, apogee_valid, landed, state, out_valid
   );

endinterface
`default_nettype wire

// File: rtl/get_altitude_integrator.sv
`default_nettype none
// ---------------------------------------------------------------------------
// altitude_integrator : fm altitude accumulator with ground clamp, mm output
// Revision 1.0
// ---------------------------------------------------------------------------
module altitude_integrator
   import get_altitude_pkg::*;
#(
   parameter int CLK_US = 10,
   parameter int ACC_W  = 96
) (
   input  wire logic               clk,
   input  wire logic               rst,
   input  wire logic               clear,
   input  wire logic               enable,
   input  wire logic signed [63:0] v_int,
   output logic signed [63:0]      altitude,
   output logic signed [63:0]      next_alt,
   output logic                    at_ground
);

   localparam logic signed [ACC_W-1:0] STEP = ACC_W'(CLK_US);
   localparam logic signed [ACC_W-1:0] FM   = ACC_W'(FM_PER_MM);

   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic signed [ACC_W-1:0] v_ext, prod, sum;
   logic signed [63:0]      altitude_q, altitude_d;

   always_comb begin
      v_ext     = ACC_W'(v_int);
      prod      = v_ext * STEP;
      sum       = acc_q + prod;
      at_ground = (sum <= 0);
      acc_d     = acc_q;
      if (clear) begin
         acc_d = '0;
      end else if (enable) begin
         // Zero or below means on the ground; the accumulator never goes negative.
         acc_d = at_ground ? '0 : sum;
      end
      altitude_d = 64'(acc_q / FM);
      next_alt   = 64'(acc_d / FM);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q      <= '0;
         altitude_q <= '0;
      end else begin
         acc_q      <= acc_d;
         altitude_q <= altitude_d;
      end
   end

   assign altitude = altitude_q;

endmodule
`default_nettype wire

// File: rtl/get_altitude.sv
`default_nettype none
// ---------------------------------------------------------------------------
// get_altitude : flight FSM integrating velocity into altitude, apogee/landing
// Revision 1.0
// ---------------------------------------------------------------------------
module get_altitude
   import get_altitude_pkg::*;
#(
   parameter int CLK_US  = 10,
   parameter int GRAVITY = GRAVITY_DEFAULT,
   parameter int ACC_W   = 96
) (
   input  wire logic     clk,
   input  wire logic     resetb,
   get_altitude_if.slave bus
);

   localparam logic signed [63:0] DV = 64'(longint'(GRAVITY) * longint'(CLK_US));

   state_e             state_q, state_d;
   logic signed [63:0] v_int_q, v_int_d;
   logic signed [63:0] apogee_q, apogee_d;
   logic               apogee_valid_q, apogee_valid_d;
   logic               landed_q, landed_d;
   logic               out_valid_q, out_valid_d;

   logic               int_clear, int_enable, at_ground;
   logic signed [63:0] altitude, next_alt;
   logic signed [63:0] v_sample, v_coast;

   always_comb begin
      v_sample       = bus.velocity * NM_PER_MM;
      if (bus.backward) v_sample = -v_sample;
      v_coast        = v_int_q - DV;
      state_d        = state_q;
      v_int_d        = v_int_q;
      apogee_d       = apogee_q;
      apogee_valid_d = 1'b0;
      int_clear      = 1'b0;
      int_enable     = 1'b0;
      case (state_q)
         S_IDLE: begin
            int_clear = 1'b1;
            v_int_d   = '0;
            if (bus.launch) state_d = S_BURN;
         end
         S_BURN: begin
            int_enable = 1'b1;
            v_int_d    = v_sample;
            if (bus.ignition_end) state_d = S_COAST;
         end
         S_COAST: begin
            int_enable = 1'b1;
            v_int_d    = v_coast;
            // Also fires on the first cycle when coast starts with non-positive velocity.
            if (v_coast <= 0) begin
               apogee_d       = next_alt;
               apogee_valid_d = 1'b1;
               state_d        = S_DESCENT;
            end
         end
         S_DESCENT: begin
            int_enable = 1'b1;
            v_int_d    = v_coast;
            if (at_ground) begin
               v_int_d = '0;
               state_d = S_LANDED;
            end
         end
         S_LANDED: begin
            if (bus.launch) begin
               int_clear = 1'b1;
               v_int_d   = '0;
               apogee_d  = '0;
               state_d   = S_BURN;
            end
         end
         default: state_d = S_IDLE;
      endcase
      landed_d    = (state_d == S_LANDED);
      out_valid_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (resetb) begin
         state_q        <= S_IDLE;
         v_int_q        <= '0;
         apogee_q       <= '0;
         apogee_valid_q <= 1'b0;
         landed_q       <= 1'b0;
         out_valid_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         v_int_q        <= v_int_d;
         apogee_q       <= apogee_d;
         apogee_valid_q <= apogee_valid_d;
         landed_q       <= landed_d;
         out_valid_q    <= out_valid_d;
      end
   end

   altitude_integrator #(
      .CLK_US (CLK_US),
      .ACC_W  (ACC_W)
   ) u_integrator (
      .clk       (clk),
      .rst       (resetb),
      .clear     (int_clear),
      .enable    (int_enable),
      .v_int     (v_int_q),
      .altitude  (altitude),
      .next_alt  (next_alt),
      .at_ground (at_ground)
   );

   assign bus.altitude     = altitude;
   assign bus.apogee       = apogee_q;
   assign bus.apogee_valid = apogee_valid_q;
   assign bus.landed       = landed_q;
   assign bus.state        = state_q;
   assign bus.out_valid    = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_get_altitude.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_get_altitude : directed flights with hand-computed altitude and apogee
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_get_altitude;

   logic clk = 1'b0;
   logic resetb;
   int   assert_cnt = 0;
   int   fail_cnt   = 0;
   int   cnt;
   int   pulses;
   logic neg_seen;

   get_altitude_if bus ();

   get_altitude #(
      .CLK_US  (1000),
      .GRAVITY (9_799),
      .ACC_W   (96)
   ) dut (
      .clk    (clk),
      .resetb (resetb),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic signed [63:0] got,
                            input logic signed [63:0] exp);
      assert_cnt++;
      if (got !== exp) begin
         fail_cnt++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string tag);
      check_val({tag, "_state"},     64'(bus.state), 0);
      check_val({tag, "_altitude"},  bus.altitude, 0);
      check_val({tag, "_apogee"},    bus.apogee, 0);
      check_val({tag, "_landed"},    64'(bus.landed), 0);
      check_val({tag, "_out_valid"}, 64'(bus.out_valid), 0);
   endtask

   // Launch pulse; afterwards n ticks of burn give altitude (n-2)*v/1000 mm at CLK_US=1000.
   task automatic do_launch(input longint v, input logic back);
      bus.velocity     = v;
      bus.backward     = back;
      bus.ignition_end = 1'b0;
      bus.launch       = 1'b1;
      tick();
      bus.launch       = 1'b0;
   endtask

   task automatic do_reset();
      resetb = 1'b1;
      tick();
      resetb = 1'b0;
   endtask

   initial begin
      resetb           = 1'b1;
      bus.launch       = 1'b0;
      bus.velocity     = '0;
      bus.backward     = 1'b0;
      bus.ignition_end = 1'b0;
      tick();
      tick();
      resetb = 1'b0;
      check_idle("reset");
      check_val("reset_apogee_valid", 64'(bus.apogee_valid), 0);

      // Short ballistic flight, reset while descending.
      do_launch(9799, 1'b0);
      check_val("f1_state_burn", 64'(bus.state), 1);
      check_val("f1_out_valid", 64'(bus.out_valid), 1);
      repeat (100) tick();
      bus.ignition_end = 1'b1;
      tick();
      check_val("f1_state_coast", 64'(bus.state), 2);
      cnt = 0;
      while (cnt < 2000 && bus.apogee_valid !== 1'b1) begin
         tick();
         cnt++;
      end
      check_val("f1_coast_cycles", cnt, 1000);
      check_val("f1_apogee", bus.apogee, 5884);
      check_val("f1_state_descent", 64'(bus.state), 3);
      repeat (5) tick();
      bus.ignition_end = 1'b0;
      do_reset();
      check_idle("mid_descent_reset");

      // Constant burn at 1000 mm/s from IDLE.
      do_launch(1000, 1'b0);
      repeat (502) tick();
      check_val("burn_alt_500", bus.altitude, 500);
      repeat (500) tick();
      check_val("burn_alt_1000", bus.altitude, 1000);
      check_val("burn_state", 64'(bus.state), 1);
      do_reset();
      check_val("burn_reset_state", 64'(bus.state), 0);

      // Full ballistic flight: 1000 mm*9.799 burn altitude, launch pulsed mid-coast.
      do_launch(9799, 1'b0);
      repeat (1000) tick();
      bus.ignition_end = 1'b1;
      tick();
      check_val("f3_state_coast", 64'(bus.state), 2);
      cnt = 0;
      while (cnt < 2000 && bus.apogee_valid !== 1'b1) begin
         bus.launch = (cnt == 500);
         tick();
         cnt++;
         if (cnt == 501) check_val("launch_in_coast", 64'(bus.state), 2);
      end
      bus.launch = 1'b0;
      check_val("f3_coast_cycles", cnt, 1000);
      check_val("f3_apogee", bus.apogee, 14703);
      check_val("f3_state_descent", 64'(bus.state), 3);
      cnt      = 0;
      pulses   = 0;
      neg_seen = 1'b0;
      while (cnt < 5000 && bus.landed !== 1'b1) begin
         tick();
         cnt++;
         if (bus.apogee_valid === 1'b1) pulses++;
         if (bus.altitude < 0) neg_seen = 1'b1;
      end
      check_val("f3_descent_cycles", cnt, 1733);
      check_val("f3_extra_apogee_pulses", pulses, 0);
      check_val("f3_negative_altitude", 64'(neg_seen), 0);
      check_val("f3_state_landed", 64'(bus.state), 4);
      bus.ignition_end = 1'b0;
      tick();
      check_val("f3_ground_altitude", bus.altitude, 0);
      check_val("f3_landed", 64'(bus.landed), 1);
      check_val("f3_apogee_held", bus.apogee, 14703);

      // Relaunch from LANDED with reversed thrust from the ground.
      do_launch(500, 1'b1);
      check_val("relaunch_state", 64'(bus.state), 1);
      check_val("relaunch_landed", 64'(bus.landed), 0);
      check_val("relaunch_apogee", bus.apogee, 0);
      repeat (50) tick();
      check_val("backward_clamp_alt", bus.altitude, 0);
      check_val("backward_state", 64'(bus.state), 1);
      bus.ignition_end = 1'b1;
      tick();
      check_val("backward_coast", 64'(bus.state), 2);
      tick();
      check_val("backward_apogee_valid", 64'(bus.apogee_valid), 1);
      check_val("backward_apogee", bus.apogee, 0);
      check_val("backward_descent", 64'(bus.state), 3);
      tick();
      check_val("backward_landed_state", 64'(bus.state), 4);
      check_val("backward_landed", 64'(bus.landed), 1);
      check_val("backward_pulse_done", 64'(bus.apogee_valid), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
      $finish;
   end

endmodule
`default_nettype wire
